// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file sweep reader.
//   ADDR_W / DATA_W / NREGS : register file geometry (address math wraps mod NREGS)
//   state_t                 : sweep sequencer states
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/sweep_addr_gen.sv
// Sweep pointer / word counter.
//   clk, reset       : clock, async active-low reset
//   load             : latch first_addr and word count N=((last-first) mod NREGS)+1
//   advance          : step to the next beat (ptr += 2, remaining -= 2)
//   first_addr/last_addr : sweep range (inclusive, may wrap)
//   ptr, ptr_hi      : lane 0 / lane 1 read addresses, both registered
//   remaining        : words left including the current beat (1..NREGS)
//   last_beat        : current beat is the final one
//   odd_tail         : current beat carries only lane 0
module sweep_addr_gen
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_hi,
  output logic [ADDR_W:0]   remaining,
  output logic              last_beat,
  output logic              odd_tail
);
  // Truncating subtraction gives the mod-NREGS span directly.
  logic [ADDR_W-1:0] span;
  assign span = last_addr - first_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      ptr_hi    <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= first_addr;
      ptr_hi    <= first_addr + ADDR_W'(1);
      remaining <= {1'b0, span} + (ADDR_W+1)'(1);
    end else if (advance) begin
      ptr       <= ptr + ADDR_W'(2);
      ptr_hi    <= ptr_hi + ADDR_W'(2);
      remaining <= remaining - (ADDR_W+1)'(2);
    end
  end

  assign last_beat = (remaining <= (ADDR_W+1)'(2));
  assign odd_tail  = (remaining == (ADDR_W+1)'(1));
endmodule

// File: rtl/regfile_sweep_reader.sv
// Read-side sequencer for the 32x32 register file. A start pulse sweeps
// first_addr..last_addr (wrapping), reading two registers per beat and
// streaming {lane1,lane0} on a valid/ready port, while accumulating a
// checksum of every valid word.
//   clk, reset          : clock, async active-low reset
//   start, abort        : sweep request (IDLE only) / synchronous cancel
//   first_addr,last_addr: inclusive sweep range, sampled on accepted start
//   sr1, sr2, rdData1/2 : register file read ports (combinational data)
//   out_*               : beat stream; out_mask=01 marks an odd final beat
//   busy, done          : status; done pulses once after the final handshake
//   checksum            : running sum of valid words, held until next start
module regfile_sweep_reader
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  output logic [ADDR_W-1:0]   sr1,
  output logic [ADDR_W-1:0]   sr2,
  input  logic [DATA_W-1:0]   rdData1,
  input  logic [DATA_W-1:0]   rdData2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [2*DATA_W-1:0] out_data,
  output logic [1:0]          out_mask,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum
);
  state_t            state;
  logic [ADDR_W-1:0] ptr, ptr_hi;
  logic [ADDR_W:0]   remaining;
  logic              last_beat, odd_tail;
  logic              load, advance, hs, abort_now;
  logic [DATA_W-1:0] lane1_word;

  assign abort_now = abort && (state != S_IDLE);
  assign hs        = out_valid && out_ready;
  assign load      = (state == S_IDLE) && start && !abort;
  // abort wins over a simultaneous handshake, so the pointer must not move
  assign advance   = (state == S_HOLD) && hs && !out_last && !abort;

  sweep_addr_gen u_addr (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .ptr        (ptr),
    .ptr_hi     (ptr_hi),
    .remaining  (remaining),
    .last_beat  (last_beat),
    .odd_tail   (odd_tail)
  );

  assign sr1  = ptr;
  assign sr2  = ptr_hi;
  assign busy = (state != S_IDLE);

  // Lane 1 of an odd final beat lies outside the range: zero it in both
  // the output and the checksum.
  assign lane1_word = odd_tail ? '0 : rdData2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (load) begin
            checksum <= '0;
            state    <= S_READ;
          end
          S_READ: begin
            out_data  <= {lane1_word, rdData1};
            out_valid <= 1'b1;
            out_mask  <= odd_tail ? 2'b01 : 2'b11;
            out_last  <= last_beat;
            out_addr  <= ptr;
            checksum  <= checksum + rdData1 + lane1_word;
            state     <= S_HOLD;
          end
          S_HOLD: if (hs) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_READ;
            end
          end
          S_DONE: begin
            out_last <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_sweep_reader.sv
// Directed bench for regfile_sweep_reader. Models the register file as a
// combinational array preloaded with reg[k] = 10*k.
module tb_regfile_sweep_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [4:0]  first_addr, last_addr;
  logic [4:0]  sr1, sr2;
  logic [31:0] rdData1, rdData2;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [63:0] out_data;
  logic [1:0]  out_mask;
  logic        out_last, busy, done;
  logic [31:0] checksum;

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdData1 = mem[sr1];
  assign rdData2 = mem[sr2];

  regfile_sweep_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_mask(out_mask), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  // Runs one sweep with out_ready=1, optionally stalling 5 cycles on
  // stall_beat and pulsing a stray start (first=5) on glitch_beat.
  task automatic run_sweep(input string tag, input logic [4:0] f, input logic [4:0] l,
                           input int stall_beat, input int glitch_beat,
                           input logic [31:0] cks_exp);
    int n, beats, cyc, rem;
    logic [4:0]  a_e;
    logic [4:0]  a_hi;
    logic [63:0] d_e;
    logic [1:0]  m_e;
    n = int'(5'(l - f)) + 1;
    beats = (n + 1) / 2;
    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":busy"}, busy, 1);
    for (int b = 0; b < beats; b++) begin
      wait_valid(cyc);
      chk({tag, ":beat_latency"}, cyc, 1);
      rem  = n - 2 * b;
      a_e  = 5'(f + 5'(2 * b));
      a_hi = a_e + 5'd1;
      m_e  = (rem == 1) ? 2'b01 : 2'b11;
      d_e  = {(rem == 1) ? 32'd0 : 32'(10 * a_hi), 32'(10 * a_e)};
      chk({tag, ":addr"}, out_addr, a_e);
      chk({tag, ":data"}, out_data, d_e);
      chk({tag, ":mask"}, out_mask, m_e);
      chk({tag, ":last"}, out_last, (rem <= 2));
      chk({tag, ":sr1"}, sr1, a_e);
      chk({tag, ":sr2"}, sr2, a_hi);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, ":stall_valid"}, out_valid, 1);
          chk({tag, ":stall_addr"}, out_addr, a_e);
          chk({tag, ":stall_data"}, out_data, d_e);
        end
        out_ready = 1'b1;
      end
      if (b == glitch_beat) begin
        start = 1'b1; first_addr = 5'd5;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, ":done_pulse"}, done, 1);
    @(negedge clk);
    chk({tag, ":done_clear"}, done, 0);
    chk({tag, ":busy_clear"}, busy, 0);
    chk({tag, ":checksum"}, checksum, cks_exp);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 32; k++) mem[k] = 32'(10 * k);
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    #12;
    chk("rst:valid", out_valid, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:checksum", checksum, 0);
    chk("rst:sr1", sr1, 0);
    chk("rst:sr2", sr2, 0);
    chk("rst:data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // start together with abort in IDLE is ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort:busy", busy, 0);

    run_sweep("full",    5'd0,  5'd31, -1, -1, 32'd4960);
    run_sweep("odd",     5'd3,  5'd7,  -1, -1, 32'd250);
    run_sweep("wrap",    5'd30, 5'd1,  -1, -1, 32'd620);
    run_sweep("single",  5'd9,  5'd9,  -1, -1, 32'd90);
    run_sweep("stall",   5'd0,  5'd31,  1, -1, 32'd4960);
    run_sweep("glitch",  5'd0,  5'd31, -1,  1, 32'd4960);

    // abort on beat 3 (with out_ready high, abort beats the handshake)
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wait_valid(cyc);
      if (b < 2) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort:valid", out_valid, 0);
    chk("abort:busy", busy, 0);
    chk("abort:done", done, 0);
    chk("abort:checksum", checksum, 150);
    repeat (3) begin
      @(negedge clk);
      chk("abort:no_done", done, 0);
    end
    run_sweep("post_abort", 5'd0, 5'd31, -1, -1, 32'd4960);

    // reset low on beat 3
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wait_valid(cyc);
      if (b < 2) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("mid_rst:valid", out_valid, 0);
    chk("mid_rst:busy", busy, 0);
    chk("mid_rst:checksum", checksum, 0);
    chk("mid_rst:sr1", sr1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst:no_done", done, 0);
    run_sweep("post_reset", 5'd0, 5'd31, -1, -1, 32'd4960);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
